// File: rtl/synth_pkg.sv
// Shared synth constants and the DAC serialiser state type.
package synth_pkg;

  localparam logic [7:0]  DAC_CMD      = 8'h00;
  localparam logic [15:0] DAC_MIDSCALE = 16'h8000;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StGap
  } dac_state_e;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider producing a registered one-cycle tick every SAMPLE_DIV cycles while enabled.
module sample_tick_gen #(
  parameter int unsigned SAMPLE_DIV = 1136
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned PreIdx = (SAMPLE_DIV > 1) ? SAMPLE_DIV - 2 : 0;

  logic [CntW-1:0] cnt_q;
  logic            tick_q;
  logic            pre_tick;

  // Decode one count early so the tick leaves a flop while the count reads SAMPLE_DIV-1.
  always_comb begin
    pre_tick = 1'b0;
    if (SAMPLE_DIV == 1) begin
      pre_tick = en;
    end else begin
      pre_tick = en && (cnt_q == CntW'(PreIdx));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= pre_tick;
      if (!en) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(SAMPLE_DIV - 1)) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/dac_spi_tx.sv
// Ships one command+sample frame to an SPI DAC per sample tick. Optional DAC_TX_MUTE_EN adds i_mute.
module dac_spi_tx
  import synth_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned SAMPLE_DIV = 1136,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned CMD_W      = 8
) (
  input  logic              i_clk50mhz,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
`ifdef DAC_TX_MUTE_EN
  input  logic              i_mute,
`endif
  output logic              o_sample_strobe,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_dac_cs_n,
  output logic              o_dac_sclk,
  output logic              o_dac_mosi
);

  localparam int unsigned FrameW = CMD_W + DATA_W;
  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW   = $clog2(FrameW);
  localparam int unsigned GapPre = (CLK_DIV > 1) ? CLK_DIV - 2 : 0;

  logic tick;

  sample_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .clk  (i_clk50mhz),
    .rst_n(i_rst_n),
    .en   (i_en),
    .tick (tick)
  );

  logic [DATA_W-1:0] sample;
  logic [FrameW-1:0] frame;

  always_comb begin
    sample = i_data;
`ifdef DAC_TX_MUTE_EN
    if (i_mute) begin
      sample = DATA_W'(DAC_MIDSCALE);
    end
`endif
  end

  assign frame = {CMD_W'(DAC_CMD), sample};

  dac_state_e        state_q;
  logic [FrameW-1:0] shreg_q;
  logic [DivW-1:0]   div_q;
  logic [BitW-1:0]   bit_q;
  logic              cs_n_q;
  logic              sclk_q;
  logic              mosi_q;
  logic              busy_q;
  logic              done_q;
  logic              phase_end;

  assign phase_end = (div_q == DivW'(CLK_DIV - 1));

  always_ff @(posedge i_clk50mhz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      shreg_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // The load is registered on the tick edge so LOAD is also the first low cycle of bit 0.
          if (tick) begin
            state_q <= StLoad;
            shreg_q <= frame;
            mosi_q  <= frame[FrameW-1];
            cs_n_q  <= 1'b0;
            sclk_q  <= 1'b0;
            busy_q  <= 1'b1;
            div_q   <= '0;
            bit_q   <= '0;
          end
        end
        StLoad, StShift: begin
          if (state_q == StLoad) begin
            state_q <= StShift;
          end
          if (!phase_end) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else if (bit_q == BitW'(FrameW - 1)) begin
              sclk_q  <= 1'b0;
              cs_n_q  <= 1'b1;
              mosi_q  <= 1'b0;
              state_q <= StGap;
              done_q  <= (CLK_DIV == 1);
            end else begin
              sclk_q  <= 1'b0;
              shreg_q <= shreg_q << 1;
              mosi_q  <= shreg_q[FrameW-2];
              bit_q   <= bit_q + 1'b1;
            end
          end
        end
        StGap: begin
          if (!phase_end) begin
            div_q  <= div_q + 1'b1;
            done_q <= (div_q == DivW'(GapPre));
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_sample_strobe = tick;
  assign o_busy          = busy_q;
  assign o_frame_done    = done_q;
  assign o_dac_cs_n      = cs_n_q;
  assign o_dac_sclk      = sclk_q;
  assign o_dac_mosi      = mosi_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Randomised bench for dac_spi_tx: a frame-level monitor rebuilds each frame from SCLK rises.
module tb_dac_spi_tx;

  localparam int unsigned ClkDiv    = 2;
  localparam int unsigned SampleDiv = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] data;
`ifdef DAC_TX_MUTE_EN
  logic        mute;
`endif
  logic        strobe, busy, frame_done, cs_n, sclk, mosi;

  dac_spi_tx #(
    .CLK_DIV   (ClkDiv),
    .SAMPLE_DIV(SampleDiv),
    .DATA_W    (16),
    .CMD_W     (8)
  ) dut (
    .i_clk50mhz     (clk),
    .i_rst_n        (rst_n),
    .i_en           (en),
    .i_data         (data),
`ifdef DAC_TX_MUTE_EN
    .i_mute         (mute),
`endif
    .o_sample_strobe(strobe),
    .o_busy         (busy),
    .o_frame_done   (frame_done),
    .o_dac_cs_n     (cs_n),
    .o_dac_sclk     (sclk),
    .o_dac_mosi     (mosi)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Frame-level reference: each frame is {8'h00, sample-at-strobe}, 24 bits MSB first.
  int          n_strobes = 0;
  int          frames_done = 0;
  int          last_strobe_cyc = 0;
  int          prev_strobe_cyc = 0;
  bit          have_prev_strobe = 0;
  bit          period_chk = 0;
  bit          in_frame = 0;
  bit          first_pend = 0;
  bit          busy_pend = 0;
  logic [23:0] exp_frame;
  logic [23:0] cap;
  logic [23:0] last_cap;
  int          rises, cs_low;
  logic        prev_sclk = 1'b0;
  logic        prev_mosi = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0;
      first_pend = 0;
      busy_pend = 0;
      have_prev_strobe = 0;
      prev_sclk = 1'b0;
    end else begin
      if (busy_pend) begin
        check_eq("busy_fall", busy, 1'b0);
        busy_pend = 0;
      end
      if (first_pend) begin
        check_eq("load_cs_n", cs_n, 1'b0);
        check_eq("load_busy", busy, 1'b1);
        check_eq("load_mosi", mosi, exp_frame[23]);
        first_pend = 0;
      end
      if (strobe) begin
        n_strobes++;
        if (period_chk && have_prev_strobe) check_eq("period", cyc - prev_strobe_cyc, SampleDiv);
        prev_strobe_cyc = cyc;
        have_prev_strobe = 1;
        last_strobe_cyc = cyc;
        exp_frame = {8'h00, data};
`ifdef DAC_TX_MUTE_EN
        if (mute) exp_frame = 24'h008000;
`endif
        in_frame = 1;
        first_pend = 1;
        rises = 0;
        cs_low = 0;
        cap = '0;
      end else if (in_frame) begin
        if (!cs_n) cs_low++;
        if (sclk && !prev_sclk) begin
          rises++;
          cap = {cap[22:0], mosi};
        end
        if (sclk && prev_sclk && !cs_n) check_eq("mosi_hold_hi", mosi, prev_mosi);
        if (frame_done) begin
          check_eq("sclk_rises", rises, 24);
          check_eq("frame_bits", cap, exp_frame);
          check_eq("cs_low_len", cs_low, 2 * 24 * ClkDiv);
          check_eq("done_latency", cyc - last_strobe_cyc, 49 * ClkDiv);
          last_cap = cap;
          in_frame = 0;
          busy_pend = 1;
          frames_done++;
        end
      end
      prev_sclk = sclk;
      prev_mosi = mosi;
    end
  end

  task automatic wait_frames(input int target);
    int budget = 4000;
    while (frames_done < target && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check_eq("wait_frames", frames_done, target);
  endtask

  task automatic wait_strobe();
    int start = n_strobes;
    int budget = 1000;
    while (n_strobes == start && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check_eq("wait_strobe", n_strobes, start + 1);
  endtask

  int c0, ns, nf, bad;

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    data  = '0;
`ifdef DAC_TX_MUTE_EN
    mute  = 1'b0;
`endif
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_cs_n", cs_n, 1'b1);
    check_eq("rst_sclk", sclk, 1'b0);
    check_eq("rst_mosi", mosi, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_strobe", strobe, 1'b0);
    check_eq("rst_done", frame_done, 1'b0);

    @(posedge clk); #1 rst_n = 1'b1;
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (strobe || !cs_n) bad++;
    end
    check_eq("idle_disabled", bad, 0);
    check_eq("idle_strobes", n_strobes, 0);

    // Single frame with a known pattern and first-strobe latency.
    @(posedge clk); #1;
    en = 1'b1;
    data = 16'hA55A;
    c0 = cyc;
    wait_strobe();
    check_eq("first_strobe", last_strobe_cyc - c0, SampleDiv - 1);
    wait_frames(1);
    check_eq("a55a_frame", last_cap, 24'h00A55A);

    // Five back-to-back frames with data changing every cycle.
    period_chk = 1;
    nf = frames_done + 5;
    for (int i = 0; i < 5 * SampleDiv + 400 && frames_done < nf; i++) begin
      @(posedge clk); #1;
      data = 16'($urandom);
`ifdef DAC_TX_MUTE_EN
      mute = 1'($urandom);
`endif
    end
    check_eq("period_frames", frames_done, nf);
    period_chk = 0;
`ifdef DAC_TX_MUTE_EN
    mute = 1'b0;
`endif

    // Enable drop mid-frame: frame completes, then silence.
    data = 16'($urandom);
    wait_strobe();
    repeat (19) @(posedge clk);
    #1 en = 1'b0;
    wait_frames(frames_done + 1);
    ns = n_strobes;
    repeat (1000) @(posedge clk);
    check_eq("no_strobe_off", n_strobes, ns);

    // Reset mid-frame.
    @(posedge clk); #1;
    en = 1'b1;
    data = 16'($urandom);
    wait_strobe();
    repeat (49) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check_eq("abort_cs_n", cs_n, 1'b1);
    check_eq("abort_sclk", sclk, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    c0 = cyc;
    wait_strobe();
    check_eq("strobe_after_rst", last_strobe_cyc - c0, SampleDiv - 1);
    wait_frames(frames_done + 1);

`ifdef DAC_TX_MUTE_EN
    // Mute forces midscale; unmuted sends the sample.
    data = 16'h1234;
    mute = 1'b1;
    wait_frames(frames_done + 1);
    wait_frames(frames_done + 1);
    check_eq("mute_frame", last_cap, 24'h008000);
    mute = 1'b0;
    wait_frames(frames_done + 1);
    wait_frames(frames_done + 1);
    check_eq("unmute_frame", last_cap, 24'h001234);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
